pipeline_flush_ctrl: RTL and testbench
======================================

// Module: pipeline_flush_ctrl
// PURPOSE
//  Parametrised pipeline controller for the CPU core: merges N stall requests into a per-stage stall vector
//  and turns exceptions/ERET into a flush plus redirect PC. Exceptions raised while a bus access is in flight
//  are held pending until the bus goes idle. Also provides a stall-timeout watchdog and saturating perf counters.
// PARAMETERS
//  N_STAGES      6             stall vector width; bit0=PC, bit1=IF ... bit5=WB
//  N_STALL_SRC   3             number of stall request sources
//  STALL_DEPTHS  {4'd3,4'd2,4'd1}  packed 4-bit field per source (src0 = LSBs); src i stalls stages [0..DEPTH_i]
//  PC_W          32            PC width
//  RESET_ADDR    32'hBFC00000  new_pc_o value when no redirect
//  EXCP_VECTOR   32'hBFC00380  target for all exceptions except ERET
//  TIMEOUT_CYC   1024          consecutive stalled cycles before watchdog fires
//  CNT_W         32            perf counter width
// PORTS
//  clk             in   1              clock
//  rst             in   1              synchronous reset, active-high
//  stallreq_i      in   N_STALL_SRC    per-source stall request (src0=bus, src1=id, src2=ex by default)
//  bus_busy_i      in   1              bus transaction outstanding; cannot be cancelled
//  excp_valid_i    in   1              exception/ERET presented this cycle (from MEM stage)
//  excp_code_i     in   5              0=Int 8=Sys 10=RI 12=Ov 31=ERET; other codes -> EXCP_VECTOR
//  cp0_epc_i       in   PC_W           EPC, used for ERET
//  stall_o         out  N_STAGES       per-stage stall
//  flush_o         out  1              flush all stages, one cycle
//  new_pc_o        out  PC_W           redirect target, valid when flush_o=1
//  excp_pending_o  out  1              exception latched, waiting for bus idle
//  stall_timeout_o out  1              watchdog: stall held >= TIMEOUT_CYC cycles
//  stall_cycles_o  out  CNT_W          saturating count of cycles with stall_o!=0
//  flush_count_o   out  CNT_W          saturating count of cycles with flush_o=1
// BEHAVIOUR
//  Reset (rst=1): state RUN; stall_o=0, flush_o=0, new_pc_o=RESET_ADDR, pending latch, watchdog, counters -> 0.
//  Target: code 31 -> EPC, else EXCP_VECTOR. new_pc_o=RESET_ADDR whenever flush_o=0.
//  FSM states RUN, PEND.
//  RUN, excp_valid_i=1, bus_busy_i=0: same cycle (combinational) flush_o=1, stall_o=0, new_pc_o=target(cp0_epc_i); stay RUN.
//  RUN, excp_valid_i=1, bus_busy_i=1: flush_o=0, stall_o=all ones; latch code and cp0_epc_i; next state PEND.
//  RUN, no exception: stall_o = OR over i of stallreq_i[i] ? mask(0..DEPTH_i) : 0; flush_o=0.
//  PEND, bus_busy_i=1: stall_o=all ones, flush_o=0, excp_pending_o=1; new exceptions ignored.
//  PEND, bus_busy_i=0: flush_o=1, stall_o=0, new_pc_o=target from latched code/EPC; next RUN. Same-cycle excp_valid_i dropped.
//  excp_pending_o = (state==PEND), registered.
//  Watchdog cnt: +1 (saturating at TIMEOUT_CYC) each cycle stall_o!=0 and flush_o=0; clears on stall_o==0 or flush_o=1.
//   stall_timeout_o = (cnt>=TIMEOUT_CYC), registered from cnt; deasserts the cycle after the stall drops.
//  Perf counters increment on the clock edge ending a qualifying cycle; hold at all ones (no wrap).
//  DEPTH_i >= N_STAGES clamps to all stages.
// TESTING
//  rst=1 two cycles with stallreq_i=3'b111 -> stall_o=0, flush_o=0, new_pc_o=32'hBFC00000, counters 0.
//  stallreq_i=3'b101, no excp -> stall_o=6'b001111; 3'b010 -> 6'b000111; after 5 such cycles stall_cycles_o=5.
//  excp_valid_i=1 code=12, bus idle, stallreq_i=3'b100 -> same cycle flush_o=1, stall_o=0, new_pc_o=32'hBFC00380; flush_count_o=1 next.
//  ERET, EPC=32'h80001000, bus_busy_i high 3 cycles, EPC changed to 32'h0 meanwhile -> 3 cycles stall_o=6'b111111,
//   excp_pending_o=1; busy drops -> flush_o=1, new_pc_o=32'h80001000, next cycle RUN.
//  TIMEOUT_CYC=8, stallreq_i[1] held 12 cycles -> stall_timeout_o=1 from cycle 9; release -> 0 one cycle later.
//  rst=1 while in PEND -> next cycle RUN, excp_pending_o=0, flush_o never asserted for latched exception.

Source files
------------

// File: rtl/pipeline_flush_ctrl.sv
// Pipeline controller: merges stall requests into a per-stage stall vector, turns exceptions/ERET
// into a one-cycle flush with redirect PC, defers exceptions behind an uncancellable bus access.
`timescale 1ns/1ps
module pipeline_flush_ctrl #(
    parameter int                       N_STAGES     = 6,
    parameter int                       N_STALL_SRC  = 3,
    parameter logic [4*N_STALL_SRC-1:0] STALL_DEPTHS = {4'd3, 4'd2, 4'd1},
    parameter int                       PC_W         = 32,
    parameter logic [PC_W-1:0]          RESET_ADDR   = 32'hBFC00000,
    parameter logic [PC_W-1:0]          EXCP_VECTOR  = 32'hBFC00380,
    parameter int                       TIMEOUT_CYC  = 1024,
    parameter int                       CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_STALL_SRC-1:0] stallreq_i,
    input  logic                   bus_busy_i,
    input  logic                   excp_valid_i,
    input  logic [4:0]             excp_code_i,
    input  logic [PC_W-1:0]        cp0_epc_i,
    output logic [N_STAGES-1:0]    stall_o,
    output logic                   flush_o,
    output logic [PC_W-1:0]        new_pc_o,
    output logic                   excp_pending_o,
    output logic                   stall_timeout_o,
    output logic [CNT_W-1:0]       stall_cycles_o,
    output logic [CNT_W-1:0]       flush_count_o
);

    localparam logic [4:0]       CODE_ERET = 5'd31;
    localparam int               WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYC);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [4:0]            code_q, code_d;
    logic [PC_W-1:0]       epc_q, epc_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  stall_timeout_q, stall_timeout_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]      flush_count_q, flush_count_d;

    logic [N_STAGES-1:0]   req_mask_s;
    logic [N_STAGES-1:0]   stall_s;
    logic                  flush_s;
    logic [PC_W-1:0]       new_pc_s;

    // Depths at or beyond the last stage naturally yield an all-ones mask.
    function automatic logic [N_STAGES-1:0] depth_mask(input logic [3:0] depth);
        logic [N_STAGES-1:0] m;
        m = '0;
        for (int j = 0; j < N_STAGES; j++) begin
            m[j] = (j <= int'(depth));
        end
        return m;
    endfunction

    function automatic logic [PC_W-1:0] redirect_target(input logic [4:0]      code,
                                                        input logic [PC_W-1:0] epc);
        if (code == CODE_ERET) begin
            return epc;
        end else begin
            return EXCP_VECTOR;
        end
    endfunction

    // OR of per-source stage masks for the stall-request path.
    always_comb begin
        req_mask_s = '0;
        for (int i = 0; i < N_STALL_SRC; i++) begin
            req_mask_s = req_mask_s |
                         (stallreq_i[i] ? depth_mask(STALL_DEPTHS[4*i +: 4]) : {N_STAGES{1'b0}});
        end
    end

    // FSM state register plus the exception latch and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            code_q          <= 5'd0;
            epc_q           <= '0;
            wd_cnt_q        <= '0;
            stall_timeout_q <= 1'b0;
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            code_q          <= code_d;
            epc_q           <= epc_d;
            wd_cnt_q        <= wd_cnt_d;
            stall_timeout_q <= stall_timeout_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
        end
    end

    // Next-state logic; the exception is captured only when it must wait for the bus.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        epc_d   = epc_q;
        case (state_q)
            ST_RUN: begin
                if (excp_valid_i && bus_busy_i) begin
                    state_d = ST_PEND;
                    code_d  = excp_code_i;
                    epc_d   = cp0_epc_i;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (bus_busy_i) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Stall/flush/redirect outputs; reset forces the idle values in the same cycle.
    always_comb begin
        stall_s  = '0;
        flush_s  = 1'b0;
        new_pc_s = RESET_ADDR;
        if (rst) begin
            stall_s  = '0;
            flush_s  = 1'b0;
            new_pc_s = RESET_ADDR;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (excp_valid_i) begin
                        if (bus_busy_i) begin
                            stall_s = '1;
                        end else begin
                            flush_s  = 1'b1;
                            new_pc_s = redirect_target(excp_code_i, cp0_epc_i);
                        end
                    end else begin
                        stall_s = req_mask_s;
                    end
                end
                ST_PEND: begin
                    if (bus_busy_i) begin
                        stall_s = '1;
                    end else begin
                        flush_s  = 1'b1;
                        new_pc_s = redirect_target(code_q, epc_q);
                    end
                end
                default: begin
                    stall_s = '0;
                end
            endcase
        end
    end

    // Watchdog and saturating perf counters.
    always_comb begin
        if ((stall_s != '0) && !flush_s) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = '0;
        end
        stall_timeout_d = (wd_cnt_d >= WD_MAX);
        if ((stall_s != '0) && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (flush_s && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    assign stall_o         = stall_s;
    assign flush_o         = flush_s;
    assign new_pc_o        = new_pc_s;
    assign excp_pending_o  = (state_q == ST_PEND);
    assign stall_timeout_o = stall_timeout_q;
    assign stall_cycles_o  = stall_cycles_q;
    assign flush_count_o   = flush_count_q;

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Scoreboard bench for pipeline_flush_ctrl: expected observations queued per driven cycle,
// popped and compared at the following falling edge.
`timescale 1ns/1ps
module tb_pipeline_flush_ctrl;

    localparam logic [31:0] RST_PC  = 32'hBFC00000;
    localparam logic [31:0] EXC_PC  = 32'hBFC00380;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        pend;
        logic        to;
        logic [7:0]  sc;
        logic [7:0]  fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  stallreq = 3'b111;
    logic        bus_busy = 1'b0;
    logic        excp_valid = 1'b0;
    logic [4:0]  excp_code = 5'd0;
    logic [31:0] epc = 32'd0;

    logic [5:0]  stall_o, stall2_o;
    logic        flush_o, flush2_o;
    logic [31:0] new_pc_o, new_pc2_o;
    logic        excp_pending_o, excp_pending2_o;
    logic        stall_timeout_o, stall_timeout2_o;
    logic [7:0]  stall_cycles_o, stall_cycles2_o;
    logic [7:0]  flush_count_o, flush_count2_o;

    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];
    logic [7:0] exp_sc = 8'd0;
    logic [7:0] exp_fc = 8'd0;

    always #5 clk = ~clk;

    pipeline_flush_ctrl #(.TIMEOUT_CYC(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .bus_busy_i(bus_busy),
        .excp_valid_i(excp_valid), .excp_code_i(excp_code), .cp0_epc_i(epc),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .excp_pending_o(excp_pending_o), .stall_timeout_o(stall_timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    pipeline_flush_ctrl #(.STALL_DEPTHS(12'h327), .TIMEOUT_CYC(8), .CNT_W(8)) dut_clamp (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .bus_busy_i(bus_busy),
        .excp_valid_i(excp_valid), .excp_code_i(excp_code), .cp0_epc_i(epc),
        .stall_o(stall2_o), .flush_o(flush2_o), .new_pc_o(new_pc2_o),
        .excp_pending_o(excp_pending2_o), .stall_timeout_o(stall_timeout2_o),
        .stall_cycles_o(stall_cycles2_o), .flush_count_o(flush_count2_o)
    );

    function automatic obs_t snap();
        snap = {stall_o, flush_o, new_pc_o, excp_pending_o, stall_timeout_o,
                stall_cycles_o, flush_count_o};
    endfunction

    function automatic obs_t mk(input logic [5:0] s, input logic f, input logic [31:0] pc,
                                input logic p, input logic t);
        mk = {s, f, pc, p, t, exp_sc, exp_fc};
    endfunction

    // Advance the bench's own view of the perf counters after an expected cycle.
    task automatic account(input obs_t e, input logic r);
        if (r) begin
            exp_sc = 8'd0;
            exp_fc = 8'd0;
        end else begin
            if (e.stall != 6'd0 && exp_sc != 8'hFF) exp_sc = exp_sc + 8'd1;
            if (e.flush && exp_fc != 8'hFF) exp_fc = exp_fc + 8'd1;
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] sr, input logic bb, input logic ev,
                         input logic [4:0] code, input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst = r; stallreq = sr; bus_busy = bb; excp_valid = ev; excp_code = code; epc = pc;
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'b111, 1'b0, 1'b0, 5'd0, 32'd0);
            e = mk(6'd0, 1'b0, RST_PC, 1'b0, 1'b0);
            exp_q.push_back(e);
            account(e, 1'b1);
            @(negedge clk);
            e = exp_q.pop_front(); o = snap();
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset_%0d got %p want %p", k, o, e); end
        end
    endtask

    task automatic test_stall_merge();
        logic [2:0] sr_tab [6] = '{3'b101, 3'b010, 3'b101, 3'b010, 3'b101, 3'b000};
        logic [5:0] st_tab [6] = '{6'b001111, 6'b000111, 6'b001111, 6'b000111, 6'b001111, 6'b000000};
        logic [5:0] cl_tab [6] = '{6'b111111, 6'b000111, 6'b111111, 6'b000111, 6'b111111, 6'b000000};
        obs_t e, o;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, sr_tab[k], 1'b0, 1'b0, 5'd0, 32'd0);
            e = mk(st_tab[k], 1'b0, RST_PC, 1'b0, 1'b0);
            exp_q.push_back(e);
            account(e, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front(); o = snap();
            checks++;
            if (o !== e) begin failures++; $display("FAIL stall_merge_%0d got %p want %p", k, o, e); end
            checks++;
            if (stall2_o !== cl_tab[k]) begin
                failures++; $display("FAIL depth_clamp_%0d got %b want %b", k, stall2_o, cl_tab[k]);
            end
        end
        checks++;
        if (stall_cycles_o !== 8'd5) begin
            failures++; $display("FAIL stall_cycles_5 got %0d want 5", stall_cycles_o);
        end
    endtask

    task automatic test_excp_idle();
        logic [2:0]  sr_tab [5] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000};
        logic        ev_tab [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0]  cd_tab [5] = '{5'd12, 5'd0, 5'd31, 5'd5, 5'd0};
        logic [31:0] ep_tab [5] = '{32'd0, 32'd0, 32'h12345678, 32'h0000ABCD, 32'd0};
        logic [31:0] pc_tab [5] = '{EXC_PC, RST_PC, 32'h12345678, EXC_PC, RST_PC};
        obs_t e, o;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, sr_tab[k], 1'b0, ev_tab[k], cd_tab[k], ep_tab[k]);
            e = mk(6'd0, ev_tab[k], pc_tab[k], 1'b0, 1'b0);
            exp_q.push_back(e);
            account(e, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front(); o = snap();
            checks++;
            if (o !== e) begin failures++; $display("FAIL excp_idle_%0d got %p want %p", k, o, e); end
        end
    endtask

    task automatic test_eret_pending();
        logic        bb_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ev_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0]  cd_tab [6] = '{5'd31, 5'd12, 5'd0, 5'd8, 5'd0, 5'd0};
        logic [31:0] ep_tab [6] = '{32'h80001000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [2:0]  sr_tab [6] = '{3'b000, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [5:0]  st_tab [6] = '{6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        logic        fl_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] pc_tab [6] = '{RST_PC, RST_PC, RST_PC, 32'h80001000, RST_PC, RST_PC};
        logic        pd_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        obs_t e, o;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, sr_tab[k], bb_tab[k], ev_tab[k], cd_tab[k], ep_tab[k]);
            e = mk(st_tab[k], fl_tab[k], pc_tab[k], pd_tab[k], 1'b0);
            exp_q.push_back(e);
            account(e, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front(); o = snap();
            checks++;
            if (o !== e) begin failures++; $display("FAIL eret_pending_%0d got %p want %p", k, o, e); end
        end
    endtask

    task automatic test_watchdog();
        obs_t e, o;
        logic held;
        for (int k = 0; k < 14; k++) begin
            held = (k < 12);
            drive(1'b0, held ? 3'b010 : 3'b000, 1'b0, 1'b0, 5'd0, 32'd0);
            e = mk(held ? 6'b000111 : 6'b000000, 1'b0, RST_PC, 1'b0, (k >= 8 && k <= 12));
            exp_q.push_back(e);
            account(e, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front(); o = snap();
            checks++;
            if (o !== e) begin failures++; $display("FAIL watchdog_%0d got %p want %p", k, o, e); end
        end
    endtask

    task automatic test_reset_in_pend();
        logic        r_tab  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        bb_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        ev_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [5:0]  st_tab [4] = '{6'h3F, 6'h00, 6'h00, 6'h00};
        logic        pd_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        obs_t e, o;
        for (int k = 0; k < 4; k++) begin
            drive(r_tab[k], 3'b000, bb_tab[k], ev_tab[k], 5'd10, 32'h00004000);
            e = mk(st_tab[k], 1'b0, RST_PC, pd_tab[k], 1'b0);
            exp_q.push_back(e);
            account(e, r_tab[k]);
            @(negedge clk);
            e = exp_q.pop_front(); o = snap();
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset_in_pend_%0d got %p want %p", k, o, e); end
        end
    endtask

    task automatic test_saturation();
        obs_t e, o;
        for (int k = 0; k < 260; k++) begin
            drive(1'b0, 3'b001, 1'b0, 1'b0, 5'd0, 32'd0);
            account(mk(6'b000011, 1'b0, RST_PC, 1'b0, 1'b0), 1'b0);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0);
        e = mk(6'd0, 1'b0, RST_PC, 1'b0, 1'b1);
        exp_q.push_back(e);
        account(e, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front(); o = snap();
        checks++;
        if (o !== e) begin failures++; $display("FAIL stall_sat got %p want %p", o, e); end
        checks++;
        if (stall_cycles_o !== 8'hFF) begin
            failures++; $display("FAIL stall_sat_value got %0d want 255", stall_cycles_o);
        end
        for (int k = 0; k < 258; k++) begin
            drive(1'b0, 3'b000, 1'b0, 1'b1, 5'd0, 32'd0);
            account(mk(6'd0, 1'b1, EXC_PC, 1'b0, 1'b0), 1'b0);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0);
        e = mk(6'd0, 1'b0, RST_PC, 1'b0, 1'b0);
        exp_q.push_back(e);
        account(e, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front(); o = snap();
        checks++;
        if (o !== e) begin failures++; $display("FAIL flush_sat got %p want %p", o, e); end
        checks++;
        if (flush_count_o !== 8'hFF) begin
            failures++; $display("FAIL flush_sat_value got %0d want 255", flush_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_stall_merge();
        test_excp_idle();
        test_eret_pending();
        test_watchdog();
        test_reset_in_pend();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got time=%0t want completion", $time);
        $fatal(1, "bench time limit expired");
    end

endmodule
